onehot_checker: RTL

Synthesizable, parametrised mutual-exclusion monitor for a WIDTH-bit request/select vector. Each clock it checks the vector against the one-hot rule for the selected mode: at-most-one bit set, or exactly-one bit set. It counts violations, raises a sticky error, and captures the first offending vector and its cycle timestamp. It sits beside arbiters, mux selects and FSM state registers, and replaces ad-hoc two-signal `!(a && b)` checks with a reusable block that survives into silicon.

---
 rtl/onehot_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/onehot_checker.sv
// rtl/onehot_checker.sv - one-hot mutual-exclusion monitor; optional assertions under ONEHOT_CHK_SVA_EN
module onehot_checker #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  parameter int GRACE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] vec,
  input  logic             clr,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [WIDTH-1:0] first_vec,
  output logic [TS_W-1:0]  first_ts,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    CHECK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // GRACE of 0 and 1 both fit a 1-bit counter; both leave exactly one unchecked ARM cycle.
  localparam int               GW         = (GRACE < 2) ? 1 : $clog2(GRACE + 1);
  localparam logic [GW-1:0]    GRACE_INIT = GW'(GRACE);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t             st, st_n;
  logic [GW-1:0]      grace, grace_n;
  logic [TS_W-1:0]    ts;
  logic               err_n, pulse_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [WIDTH-1:0]   fv_n;
  logic [TS_W-1:0]    fts_n;
  logic               multi, zero, viol;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi = |(vec & (vec - WIDTH'(1)));
  assign zero  = ~|vec;
  assign viol  = multi | ((MODE == 1) & zero);
  assign state = st;

  // Free-running timestamp, independent of en and clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ARM;
      grace     <= GRACE_INIT;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      viol_cnt  <= '0;
      first_vec <= '0;
      first_ts  <= '0;
    end else begin
      st        <= st_n;
      grace     <= grace_n;
      err       <= err_n;
      err_pulse <= pulse_n;
      viol_cnt  <= cnt_n;
      first_vec <= fv_n;
      first_ts  <= fts_n;
    end
  end

  // Next-state and result logic; a violation is applied after clr so it wins.
  always_comb begin
    st_n    = st;
    grace_n = grace;
    err_n   = err;
    pulse_n = 1'b0;
    cnt_n   = viol_cnt;
    fv_n    = first_vec;
    fts_n   = first_ts;

    if (clr) begin
      err_n = 1'b0;
      cnt_n = '0;
      fv_n  = '0;
      fts_n = '0;
    end

    if (!en) begin
      st_n    = ARM;
      grace_n = GRACE_INIT;
    end else begin
      case (st)
        ARM: begin
          if (grace <= GW'(1)) begin
            st_n    = CHECK;
            grace_n = '0;
          end else begin
            grace_n = grace - GW'(1);
          end
        end
        CHECK, FAULT: begin
          if (clr) st_n = CHECK;
          if (viol) begin
            pulse_n = 1'b1;
            if (cnt_n != CNT_MAX) cnt_n = cnt_n + CNT_W'(1);
            if (!err_n) begin
              fv_n  = vec;
              fts_n = ts;
              err_n = 1'b1;
            end
            st_n = FAULT;
          end
        end
        default: begin
          st_n    = ARM;
          grace_n = GRACE_INIT;
        end
      endcase
    end
  end

`ifdef ONEHOT_CHK_SVA_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (en && (st == CHECK || st == FAULT)) |-> !viol)
    else $error("onehot_checker: violation vec=%b ts=%0d", vec, ts);

  c_zero_hot: cover property (@(posedge clk) disable iff (!rst_n) en && zero);

  c_multi_hot: cover property (@(posedge clk) disable iff (!rst_n) en && multi);
`endif

endmodule
